// File: rtl/mips_control_unit.sv
// mips_control_unit: main decoder plus ALU decoder for a single-cycle MIPS datapath.
// The decode path is purely combinational, so control is valid in the same cycle
// as the instruction. A small clocked block keeps debug state: a sticky
// illegal-instruction flag and a saturating count of legal decoded instructions.

module mips_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Instruction,
    input  logic [5:0]       Funct,
    output logic             RF_WRITE_ENABLE,
    output logic             DM_WRITE_ENABLE,
    output logic             MtoRFSEL,
    output logic             Branch,
    output logic             ALUInSel,
    output logic             RFDSel,
    output logic [2:0]       ALUsel,
    output logic             Illegal,
    output logic             IllegalSticky,
    output logic [CNT_W-1:0] DecodeCount
);

    // Opcode and funct encodings
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rfWe;
    logic             dmWe;
    logic             stickyQ;
    logic             stickyD;
    logic [CNT_W-1:0] countQ;
    logic [CNT_W-1:0] countD;

    // Main and ALU decode; the funct field is only examined inside the R-type arm
    // so that an undriven funct on memory/branch instructions cannot produce X.
    always_comb begin
        rfWe     = 1'b0;
        dmWe     = 1'b0;
        MtoRFSEL = 1'b0;
        Branch   = 1'b0;
        ALUInSel = 1'b0;
        RFDSel   = 1'b0;
        ALUsel   = ALU_ADD;
        Illegal  = 1'b1;
        case (Instruction)
            OP_RTYPE: begin
                case (Funct)
                    FN_ADD: begin
                        rfWe    = 1'b1;
                        RFDSel  = 1'b1;
                        ALUsel  = ALU_ADD;
                        Illegal = 1'b0;
                    end
                    FN_SUB: begin
                        rfWe    = 1'b1;
                        RFDSel  = 1'b1;
                        ALUsel  = ALU_SUB;
                        Illegal = 1'b0;
                    end
                    FN_AND: begin
                        rfWe    = 1'b1;
                        RFDSel  = 1'b1;
                        ALUsel  = ALU_AND;
                        Illegal = 1'b0;
                    end
                    FN_OR: begin
                        rfWe    = 1'b1;
                        RFDSel  = 1'b1;
                        ALUsel  = ALU_OR;
                        Illegal = 1'b0;
                    end
                    FN_SLT: begin
                        rfWe    = 1'b1;
                        RFDSel  = 1'b1;
                        ALUsel  = ALU_SLT;
                        Illegal = 1'b0;
                    end
                    default: begin
                        Illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                rfWe     = 1'b1;
                MtoRFSEL = 1'b1;
                ALUInSel = 1'b1;
                ALUsel   = ALU_ADD;
                Illegal  = 1'b0;
            end
            OP_SW: begin
                dmWe     = 1'b1;
                ALUInSel = 1'b1;
                ALUsel   = ALU_ADD;
                Illegal  = 1'b0;
            end
            OP_BEQ: begin
                Branch  = 1'b1;
                ALUsel  = ALU_SUB;
                Illegal = 1'b0;
            end
            default: begin
                Illegal = 1'b1;
            end
        endcase
    end

    // Write enables are gated by reset so nothing is written while the core is held.
    always_comb begin
        RF_WRITE_ENABLE = rfWe & rst_n;
        DM_WRITE_ENABLE = dmWe & rst_n;
    end

    // Next-state for debug state: sticky flag on illegal, otherwise saturating count.
    always_comb begin
        stickyD = stickyQ;
        countD  = countQ;
        if (Illegal) begin
            stickyD = 1'b1;
        end else if (countQ != CNT_MAX) begin
            countD = countQ + 1'b1;
        end
    end

    // Debug state registers, cleared asynchronously while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stickyQ <= 1'b0;
            countQ  <= '0;
        end else begin
            stickyQ <= stickyD;
            countQ  <= countD;
        end
    end

    assign IllegalSticky = stickyQ;
    assign DecodeCount   = countQ;

endmodule

// File: tb/tb_mips_control_unit.sv
// tb_mips_control_unit: scoreboard bench for mips_control_unit.
// The stimulus side drives directed vectors and pushes hand-computed expected
// decode plus expected debug-register state; a separate monitor pops and compares.

module tb_mips_control_unit;

    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic [63:0]         name;
        logic [5:0]          ctl;
        logic [2:0]          alu;
        logic                ill;
        logic                sticky;
        logic [TB_CNT_W-1:0] cnt;
    } expect_t;

    logic                clk;
    logic                rst_n;
    logic [5:0]          Instruction;
    logic [5:0]          Funct;
    logic                RF_WRITE_ENABLE;
    logic                DM_WRITE_ENABLE;
    logic                MtoRFSEL;
    logic                Branch;
    logic                ALUInSel;
    logic                RFDSel;
    logic [2:0]          ALUsel;
    logic                Illegal;
    logic                IllegalSticky;
    logic [TB_CNT_W-1:0] DecodeCount;

    expect_t             sbQueue[$];
    event                sampleEv;
    int                  vecCount;
    int                  failCount;
    int                  compCount;
    logic                modelSticky;
    logic [TB_CNT_W-1:0] modelCount;

    mips_control_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Instruction     (Instruction),
        .Funct           (Funct),
        .RF_WRITE_ENABLE (RF_WRITE_ENABLE),
        .DM_WRITE_ENABLE (DM_WRITE_ENABLE),
        .MtoRFSEL        (MtoRFSEL),
        .Branch          (Branch),
        .ALUInSel        (ALUInSel),
        .RFDSel          (RFDSel),
        .ALUsel          (ALUsel),
        .Illegal         (Illegal),
        .IllegalSticky   (IllegalSticky),
        .DecodeCount     (DecodeCount)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Push one expectation built from the hand-computed decode and the register model.
    task automatic pushExpect(input logic [63:0] name, input logic [5:0] ctl,
                              input logic [2:0] alu, input logic ill);
        expect_t e;
        e.name   = name;
        e.ctl    = rst_n ? ctl : (ctl & 6'b001111);
        e.alu    = alu;
        e.ill    = ill;
        e.sticky = modelSticky;
        e.cnt    = modelCount;
        sbQueue.push_back(e);
        vecCount++;
        -> sampleEv;
    endtask

    // Drive one instruction at a negedge; it is sampled by exactly one posedge after.
    task automatic applyStimulus(input logic [63:0] name, input logic [5:0] op,
                                 input logic [5:0] fn, input logic [5:0] ctl,
                                 input logic [2:0] alu, input logic ill);
        @(negedge clk);
        Instruction = op;
        Funct       = fn;
        pushExpect(name, ctl, alu, ill);
        if (rst_n) begin
            if (ill) modelSticky = 1'b1;
            else if (modelCount != {TB_CNT_W{1'b1}}) modelCount = modelCount + 1'b1;
        end
    endtask

    // Assert reset mid-cycle and expect debug state and write enables to clear at once.
    task automatic resetPulse(input logic [5:0] ctl, input logic [2:0] alu, input logic ill);
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        modelSticky = 1'b0;
        modelCount  = '0;
        pushExpect("rstpulse", ctl, alu, ill);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Compare one popped expectation against the DUT outputs.
    task automatic checkOutput(input expect_t e);
        logic [9:0]          gotDec;
        logic [9:0]          wantDec;
        logic [TB_CNT_W:0]   gotReg;
        logic [TB_CNT_W:0]   wantReg;
        gotDec  = {RF_WRITE_ENABLE, DM_WRITE_ENABLE, MtoRFSEL, Branch, ALUInSel,
                   RFDSel, ALUsel, Illegal};
        wantDec = {e.ctl, e.alu, e.ill};
        gotReg  = {IllegalSticky, DecodeCount};
        wantReg = {e.sticky, e.cnt};
        compCount++;
        if (gotDec !== wantDec) begin
            failCount++;
            $display("[TB] FAIL %0s decode got %b want %b", e.name, gotDec, wantDec);
        end
        compCount++;
        if (gotReg !== wantReg) begin
            failCount++;
            $display("[TB] FAIL %0s sticky/count got %b want %b", e.name, gotReg, wantReg);
        end
    endtask

    // Monitor: on each presented vector, let the decode settle and score it.
    initial begin
        forever begin
            @(sampleEv);
            #2;
            if (sbQueue.size() == 0) begin
                failCount++;
                $display("[TB] FAIL scoreboard empty on sample");
            end else begin
                checkOutput(sbQueue.pop_front());
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        vecCount    = 0;
        failCount   = 0;
        compCount   = 0;
        modelSticky = 1'b0;
        modelCount  = '0;
        rst_n       = 1'b0;
        Instruction = 6'b000000;
        Funct       = 6'b100000;

        // add while in reset: write enable masked, counters zero
        applyStimulus("add_rst ", 6'b000000, 6'b100000, 6'b100001, 3'b010, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // eight legal instructions
        applyStimulus("add     ", 6'b000000, 6'b100000, 6'b100001, 3'b010, 1'b0);
        applyStimulus("sub     ", 6'b000000, 6'b100010, 6'b100001, 3'b110, 1'b0);
        applyStimulus("and     ", 6'b000000, 6'b100100, 6'b100001, 3'b000, 1'b0);
        applyStimulus("or      ", 6'b000000, 6'b100101, 6'b100001, 3'b001, 1'b0);
        applyStimulus("slt     ", 6'b000000, 6'b101010, 6'b100001, 3'b111, 1'b0);
        applyStimulus("lw      ", 6'b100011, 6'bxxxxxx, 6'b101010, 3'b010, 1'b0);
        applyStimulus("sw      ", 6'b101011, 6'bxxxxxx, 6'b010010, 3'b010, 1'b0);
        applyStimulus("beq     ", 6'b000100, 6'bxxxxxx, 6'b000100, 3'b110, 1'b0);

        // illegal opcode, then illegal funct; count stays at 8, sticky sets
        applyStimulus("ill_op  ", 6'b000010, 6'b100000, 6'b000000, 3'b010, 1'b1);
        applyStimulus("ill_fn  ", 6'b000000, 6'b000000, 6'b000000, 3'b010, 1'b1);
        applyStimulus("add_stk ", 6'b000000, 6'b100000, 6'b100001, 3'b010, 1'b0);
        applyStimulus("lw_stk  ", 6'b100011, 6'bxxxxxx, 6'b101010, 3'b010, 1'b0);

        // asynchronous reset pulse with lw held on the inputs
        resetPulse(6'b101010, 3'b010, 1'b0);

        // saturation of the narrow counter: 17 legal then one more check
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0)
                applyStimulus("sat_add ", 6'b000000, 6'b100000, 6'b100001, 3'b010, 1'b0);
            else
                applyStimulus("sat_sw  ", 6'b101011, 6'bxxxxxx, 6'b010010, 3'b010, 1'b0);
        end
        applyStimulus("sat_beq ", 6'b000100, 6'b111111, 6'b000100, 3'b110, 1'b0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sbQueue.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        if (sbQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain pending got %0d want 0", sbQueue.size());
        end
        if (compCount != 2 * vecCount) begin
            failCount++;
            $display("[TB] FAIL checks got %0d want %0d", compCount, 2 * vecCount);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
